// File: rtl/fpu_fp80_to_uint64.sv
// fpu_fp80_to_uint64: multi-cycle conversion of an 80-bit extended-precision float
// into a 64-bit unsigned magnitude plus sign, with x87 rounding control and
// invalid/overflow/inexact flags. Fixed latency of four edges from start to done.

module fpu_fp80_to_uint64 #(
   parameter logic [63:0] INVALID_VALUE = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [79:0] fp_in,
   input  logic [1:0]  round_mode,
   output logic [63:0] uint_out,
   output logic        sign_out,
   output logic        done,
   output logic        overflow,
   output logic        invalid,
   output logic        inexact
);

   typedef enum logic [2:0] {StIdle, StUnpack, StAlign, StRound, StDone} state_e;

   state_e state_q, state_d;

   // Captured operand and rounding mode
   logic [79:0]  fp_q;
   logic [1:0]   mode_q;

   // Classification results
   logic         inv_q;
   logic         ovf_q;
   logic         tiny_q;
   logic [6:0]   shift_q;

   // Aligned integer part with guard/sticky
   logic [63:0]  int_q;
   logic         guard_q;
   logic         sticky_q;

   // Rounded result waiting to be published
   logic [63:0]  res_q;
   logic         inex_q;

   logic [14:0]        exp_w;
   logic [63:0]        mant_w;
   logic signed [16:0] shift_full;
   logic               cls_inv;
   logic               cls_ovf;
   logic               cls_tiny;
   logic [129:0]       ext_w;
   logic               inc;
   logic [64:0]        sum_w;

   assign exp_w      = fp_q[78:64];
   assign mant_w     = fp_q[63:0];
   // 16446 = bias + 63: distance from the mantissa binary point to the integer LSB
   assign shift_full = 17'sd16446 - $signed({2'b00, exp_w});

   // Operand classification
   always_comb begin
      cls_inv  = (exp_w == 15'h7FFF) || ((exp_w != 15'd0) && !mant_w[63]);
      cls_ovf  = !cls_inv && (shift_full < 17'sd0);
      // Zero/denormal or shifted so far that only the sticky bit survives
      cls_tiny = (exp_w == 15'd0) || (shift_full > 17'sd65);
   end

   // Two extra low bits keep guard and all sticky bits visible up to shift 65
   assign ext_w = {mant_w, 66'd0} >> shift_q;

   // Rounding increment per x87 rounding-control mode
   always_comb begin
      inc = 1'b0;
      case (mode_q)
         2'b00:   inc = guard_q & (sticky_q | int_q[0]);
         2'b01:   inc = fp_q[79] & (guard_q | sticky_q);
         2'b10:   inc = !fp_q[79] & (guard_q | sticky_q);
         default: inc = 1'b0;
      endcase
   end

   assign sum_w = {1'b0, int_q} + {64'd0, inc};

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state logic; DONE is left only after results are published and enable is low
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (enable) state_d = StUnpack;
         StUnpack: state_d = StAlign;
         StAlign:  state_d = StRound;
         StRound:  state_d = StDone;
         StDone:   if (done && !enable) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Datapath and output registers, one pipeline step per state
   always_ff @(posedge clk) begin
      if (reset) begin
         fp_q     <= '0;
         mode_q   <= '0;
         inv_q    <= 1'b0;
         ovf_q    <= 1'b0;
         tiny_q   <= 1'b0;
         shift_q  <= '0;
         int_q    <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         res_q    <= '0;
         inex_q   <= 1'b0;
         uint_out <= '0;
         sign_out <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         invalid  <= 1'b0;
         inexact  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (enable) begin
                  fp_q   <= fp_in;
                  mode_q <= round_mode;
               end
            end
            StUnpack: begin
               inv_q   <= cls_inv;
               ovf_q   <= cls_ovf;
               tiny_q  <= cls_tiny;
               shift_q <= shift_full[6:0];
            end
            StAlign: begin
               if (tiny_q) begin
                  int_q    <= '0;
                  guard_q  <= 1'b0;
                  sticky_q <= |mant_w;
               end else begin
                  int_q    <= ext_w[129:66];
                  guard_q  <= ext_w[65];
                  sticky_q <= |ext_w[64:0];
               end
            end
            StRound: begin
               res_q  <= sum_w[63:0];
               ovf_q  <= ovf_q | sum_w[64];
               inex_q <= guard_q | sticky_q;
            end
            StDone: begin
               if (!done) begin
                  done     <= 1'b1;
                  sign_out <= fp_q[79];
                  if (inv_q) begin
                     uint_out <= INVALID_VALUE;
                     invalid  <= 1'b1;
                     overflow <= 1'b0;
                     inexact  <= 1'b0;
                  end else if (ovf_q) begin
                     uint_out <= 64'hFFFF_FFFF_FFFF_FFFF;
                     invalid  <= 1'b0;
                     overflow <= 1'b1;
                     inexact  <= 1'b0;
                  end else begin
                     uint_out <= res_q;
                     invalid  <= 1'b0;
                     overflow <= 1'b0;
                     inexact  <= inex_q;
                  end
               end else if (!enable) begin
                  done <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_fp80_to_uint64.sv
// Self-checking bench for fpu_fp80_to_uint64: vector table driven through a
// scoreboard queue, plus hand-written reset, pulse and hold sequences.

module tb_fpu_fp80_to_uint64;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [79:0] fp_in;
   logic [1:0]  round_mode;
   logic [63:0] uint_out;
   logic        sign_out;
   logic        done;
   logic        overflow;
   logic        invalid;
   logic        inexact;

   typedef struct {
      logic [79:0] fp;
      logic [1:0]  mode;
      logic [63:0] val;
      logic        sgn;
      logic        ovf;
      logic        inv;
      logic        inex;
   } vec_t;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   vec_t vecs[22];
   vec_t exp_q[$];
   int   compared = 0;
   int   mismatched = 0;
   logic done_prev = 1'b0;

   fpu_fp80_to_uint64 dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fp_in      (fp_in),
      .round_mode (round_mode),
      .uint_out   (uint_out),
      .sign_out   (sign_out),
      .done       (done),
      .overflow   (overflow),
      .invalid    (invalid),
      .inexact    (inexact)
   );

   always #5 clk = ~clk;

   // Monitor: every rising done retires one expected record
   always @(negedge clk) begin
      vec_t e;
      if (done && !done_prev) begin
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_done: got done with empty scoreboard, val=%h", uint_out);
         end else begin
            e = exp_q.pop_front();
            if ({uint_out, sign_out, overflow, invalid, inexact} !==
                {e.val, e.sgn, e.ovf, e.inv, e.inex}) begin
               mismatched++;
               $display("FAIL result fp=%h mode=%0d: got val=%h s=%b o=%b i=%b x=%b, want val=%h s=%b o=%b i=%b x=%b",
                        e.fp, e.mode, uint_out, sign_out, overflow, invalid, inexact,
                        e.val, e.sgn, e.ovf, e.inv, e.inex);
            end
         end
      end
      done_prev = done;
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // One conversion with enable held until done; checks latency and done drop
   task automatic run_vec(input vec_t v);
      int lat = 0;
      bit got = 0;
      @(negedge clk);
      fp_in = v.fp;
      round_mode = v.mode;
      enable = 1'b1;
      exp_q.push_back(v);
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done) got = 1;
         // Operand changes after the start must not matter
         fp_in = ~v.fp;
         round_mode = ~v.mode;
      end
      check("latency", 128'(got ? lat : 99), 128'd5);
      enable = 1'b0;
      @(negedge clk);
      check("done_drop", 128'(done), 128'd0);
   endtask

   function automatic vec_t mk(input logic [79:0] fp, input logic [1:0] mode,
                               input logic [63:0] val, input logic sgn, input logic ovf,
                               input logic inv, input logic inex);
      vec_t v;
      v.fp = fp; v.mode = mode; v.val = val; v.sgn = sgn;
      v.ovf = ovf; v.inv = inv; v.inex = inex;
      return v;
   endfunction

   initial begin
      vec_t v;
      int cnt;
      bit got;

      vecs[0]  = mk(80'h3FFF_8000000000000000, 2'd0, 64'd1,   0, 0, 0, 0);
      vecs[1]  = mk(80'hC007_E400000000000000, 2'd0, 64'd456, 1, 0, 0, 0);
      vecs[2]  = mk(80'h4005_F600000000000000, 2'd0, 64'd123, 0, 0, 0, 0);
      vecs[3]  = mk(80'h4000_A000000000000000, 2'd0, 64'd2,   0, 0, 0, 1);
      vecs[4]  = mk(80'h4000_A000000000000000, 2'd1, 64'd2,   0, 0, 0, 1);
      vecs[5]  = mk(80'h4000_A000000000000000, 2'd2, 64'd3,   0, 0, 0, 1);
      vecs[6]  = mk(80'h4000_A000000000000000, 2'd3, 64'd2,   0, 0, 0, 1);
      vecs[7]  = mk(80'h3FFF_C000000000000000, 2'd0, 64'd2,   0, 0, 0, 1);
      vecs[8]  = mk(80'h3FFE_8000000000000000, 2'd2, 64'd1,   0, 0, 0, 1);
      vecs[9]  = mk(80'h3FFE_8000000000000000, 2'd0, 64'd0,   0, 0, 0, 1);
      vecs[10] = mk(80'h0000_0000000000000001, 2'd2, 64'd1,   0, 0, 0, 1);
      vecs[11] = mk(80'h0000_0000000000000000, 2'd0, 64'd0,   0, 0, 0, 0);
      vecs[12] = mk(80'h403E_FFFFFFFFFFFFFFFF, 2'd0, ONES,    0, 0, 0, 0);
      vecs[13] = mk(80'h403F_8000000000000000, 2'd0, ONES,    0, 1, 0, 0);
      vecs[14] = mk(80'h403D_FFFFFFFFFFFFFFFF, 2'd0, 64'h8000_0000_0000_0000, 0, 0, 0, 1);
      vecs[15] = mk(80'h7FFF_C000000000000000, 2'd0, ONES,    0, 0, 1, 0);
      vecs[16] = mk(80'h4000_4000000000000000, 2'd0, ONES,    0, 0, 1, 0);
      vecs[17] = mk(80'hC000_A000000000000000, 2'd1, 64'd3,   1, 0, 0, 1);
      vecs[18] = mk(80'hC000_A000000000000000, 2'd2, 64'd2,   1, 0, 0, 1);
      vecs[19] = mk(80'h8000_0000000000000000, 2'd0, 64'd0,   1, 0, 0, 0);
      vecs[20] = mk(80'h8000_0000000000000001, 2'd1, 64'd1,   1, 0, 0, 1);
      vecs[21] = mk(80'hFFFF_8000000000000000, 2'd3, ONES,    1, 0, 1, 0);

      reset = 1'b1;
      enable = 1'b0;
      fp_in = '0;
      round_mode = '0;
      repeat (3) @(negedge clk);
      check("reset_state", 128'({uint_out, sign_out, done, overflow, invalid, inexact}), 128'd0);
      reset = 1'b0;

      for (int i = 0; i < 22; i++) run_vec(vecs[i]);

      // Reset during ALIGN aborts and clears every output
      @(negedge clk);
      fp_in = 80'hC007_E400000000000000;
      round_mode = 2'd0;
      enable = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      check("reset_in_align",
            128'({uint_out, sign_out, done, overflow, invalid, inexact}), 128'd0);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("no_done_after_abort", 128'(done), 128'd0);

      // One-cycle enable pulse: conversion completes, done lasts one cycle
      @(negedge clk);
      v = mk(80'h4005_F600000000000000, 2'd0, 64'd123, 0, 0, 0, 0);
      fp_in = v.fp;
      round_mode = v.mode;
      enable = 1'b1;
      exp_q.push_back(v);
      @(negedge clk);
      enable = 1'b0;
      fp_in = '0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("pulse_done_width", 128'(cnt), 128'd1);
      check("hold_after_done", 128'(uint_out), 128'd123);

      // Idle again: a fresh start must work
      run_vec(vecs[1]);

      // enable held: done stays high, no restart after release
      @(negedge clk);
      v = vecs[5];
      fp_in = v.fp;
      round_mode = v.mode;
      enable = 1'b1;
      exp_q.push_back(v);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1;
      end
      check("held_done_seen", 128'(got), 128'd1);
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("held_done_stays", 128'(cnt), 128'd4);
      enable = 1'b0;
      @(negedge clk);
      check("held_release", 128'(done), 128'd0);
      repeat (8) @(negedge clk);
      check("no_restart", 128'(done), 128'd0);

      check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
